ftoi_pipe: RTL

FTOI_PIPE -- requirements
Module: ftoi_pipe

---
 rtl/ftoi_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ftoi_pipe.sv
// Two-stage IEEE-754 binary32 to integer converter with valid/ready flow control.
// S1 aligns the significand and extracts guard/sticky; S2 rounds, saturates and flags.
module ftoi_pipe #(
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_op,
   input  logic [2:0]       in_rm,
   input  logic             in_unsigned,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_result,
   output logic             out_nv,
   output logic             out_nx
);

   localparam int XW = OUT_W + 27;
   localparam logic [OUT_W+1:0] LIM_S = (OUT_W+2)'(1) << (OUT_W-1);
   localparam logic [8:0]       OVF_EXP = 9'(127 + OUT_W + 1);

   function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic g, input logic s);
      logic inc;
      case (rm)
         3'b001:  inc = 1'b0;
         3'b010:  inc = sign & (g | s);
         3'b011:  inc = ~sign & (g | s);
         3'b100:  inc = g;
         default: inc = g & (s | lsb);
      endcase
      return inc;
   endfunction

   function automatic logic [OUT_W-1:0] sat_val(input logic neg, input logic uns);
      logic [OUT_W-1:0] v;
      if (uns) v = neg ? '0 : '1;
      else     v = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      return v;
   endfunction

   logic             vld_p1_q, vld_p2_q;
   logic             adv_p1, adv_p2;
   logic             sign_p1_q, nan_p1_q, ovf_p1_q, g_p1_q, s_p1_q, uns_p1_q;
   logic [2:0]       rm_p1_q;
   logic [OUT_W:0]   mag_p1_q;
   logic             nan_p1_d, ovf_p1_d, g_p1_d, s_p1_d;
   logic [OUT_W:0]   mag_p1_d;
   logic [23:0]      sig;
   logic [6:0]       sh;
   logic [XW-1:0]    xal;
   logic [OUT_W-1:0] res_p2_q, res_p2_d;
   logic             nv_p2_q, nx_p2_q, nv_p2_d, nx_p2_d;
   logic             inc, inexact, in_rng;
   logic [OUT_W+1:0] rmag;

   assign adv_p2   = ~vld_p2_q | out_ready;
   assign adv_p1   = ~vld_p1_q | adv_p2;
   assign in_ready = adv_p1 & ~reset;

   // S1: decode and align; the integer part keeps one spare bit so overflow by 2x is visible
   always_comb begin
      sig      = {in_op[30:23] != 8'd0, in_op[22:0]};
      nan_p1_d = (in_op[30:23] == 8'hFF) && (in_op[22:0] != 23'd0);
      ovf_p1_d = {1'b0, in_op[30:23]} >= OVF_EXP;
      sh       = (in_op[30:23] <= 8'd125) ? 7'd1 : 7'(in_op[30:23] - 8'd124);
      xal      = XW'(sig) << sh;
      mag_p1_d = xal[XW-1:26];
      g_p1_d   = xal[25];
      s_p1_d   = |xal[24:0];
   end

   always_ff @(posedge clk) begin
      if (adv_p1 && in_valid) begin
         sign_p1_q <= in_op[31];
         nan_p1_q  <= nan_p1_d;
         ovf_p1_q  <= ovf_p1_d;
         mag_p1_q  <= mag_p1_d;
         g_p1_q    <= g_p1_d;
         s_p1_q    <= s_p1_d;
         rm_p1_q   <= in_rm;
         uns_p1_q  <= in_unsigned;
      end
   end

   // S2: round, range-check against the captured signedness, saturate
   always_comb begin
      inc      = round_inc(rm_p1_q, sign_p1_q, mag_p1_q[0], g_p1_q, s_p1_q);
      inexact  = g_p1_q | s_p1_q;
      rmag     = {1'b0, mag_p1_q} + (OUT_W+2)'(inc);
      in_rng   = sign_p1_q ? (rmag <= LIM_S) : (rmag < LIM_S);
      res_p2_d = '0;
      nv_p2_d  = 1'b0;
      nx_p2_d  = 1'b0;
      if (nan_p1_q) begin
         res_p2_d = sat_val(1'b0, uns_p1_q);
         nv_p2_d  = 1'b1;
      end else if (ovf_p1_q) begin
         res_p2_d = sat_val(sign_p1_q, uns_p1_q);
         nv_p2_d  = 1'b1;
      end else if (uns_p1_q) begin
         if (sign_p1_q) begin
            nv_p2_d = (rmag != '0);
            nx_p2_d = (rmag == '0) & inexact;
         end else if (rmag[OUT_W+1:OUT_W] != 2'b00) begin
            res_p2_d = sat_val(1'b0, 1'b1);
            nv_p2_d  = 1'b1;
         end else begin
            res_p2_d = rmag[OUT_W-1:0];
            nx_p2_d  = inexact;
         end
      end else if (!in_rng) begin
         res_p2_d = sat_val(sign_p1_q, 1'b0);
         nv_p2_d  = 1'b1;
      end else begin
         res_p2_d = sign_p1_q ? -rmag[OUT_W-1:0] : rmag[OUT_W-1:0];
         nx_p2_d  = inexact;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         res_p2_q <= '0;
         nv_p2_q  <= 1'b0;
         nx_p2_q  <= 1'b0;
      end else begin
         if (adv_p1) vld_p1_q <= in_valid;
         if (adv_p2) vld_p2_q <= vld_p1_q;
         if (adv_p2 && vld_p1_q) begin
            res_p2_q <= res_p2_d;
            nv_p2_q  <= nv_p2_d;
            nx_p2_q  <= nx_p2_d;
         end
      end
   end

   assign out_valid  = vld_p2_q;
   assign out_result = res_p2_q;
   assign out_nv     = nv_p2_q;
   assign out_nx     = nx_p2_q;

endmodule
